// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: PC controller state encoding and PC arithmetic constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_W = 16;
  localparam logic [PC_W-1:0] PC_INC = 16'd1;

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch PC controller: sequential increment, stall hold, branch redirect with IF flush, halt.
// Optional redirect counter port enabled by FETCH_PC_CTRL_REDIRECT_CNT_EN.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  input  logic            halt,
  output logic [PC_W-1:0] pc_next,
  output logic            pc_write,
  output logic            if_flush,
`ifdef FETCH_PC_CTRL_REDIRECT_CNT_EN
  output logic [15:0]     redirect_count,
`endif
  output logic            halted
);

  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         halted_q, halted_d;
  logic         redirect;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_next  = pc_cur;
    pc_write = 1'b0;
    if_flush = 1'b0;
    redirect = 1'b0;
    if (reset) begin
      state_d  = RUN;
      cnt_d    = '0;
      pc_next  = '0;
      if_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            redirect = 1'b1;
          end else if (halt) begin
            state_d = HALT;
          end else if (!stall) begin
            pc_next  = pc_cur + PC_INC;
            pc_write = 1'b1;
          end
        end
        FLUSH: begin
          if (branch_taken) begin
            redirect = 1'b1;
          end else begin
            pc_next  = pc_cur + PC_INC;
            pc_write = 1'b1;
            if_flush = 1'b1;
            // cnt_q counts flush cycles still owed, including this one.
            if (cnt_q <= 2'd1) begin
              state_d = RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
        end
        HALT: ;
        default: state_d = RUN;
      endcase

      // The redirect cycle itself is the first flush cycle.
      if (redirect) begin
        pc_next  = branch_target;
        pc_write = 1'b1;
        if_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d = FLUSH;
          cnt_d   = FLUSH_RELOAD;
        end else begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
    end
    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clock) begin
    state_q  <= state_d;
    cnt_q    <= cnt_d;
    halted_q <= halted_d;
  end

  assign halted = halted_q & ~reset;

`ifdef FETCH_PC_CTRL_REDIRECT_CNT_EN
  logic [15:0] redirect_count_q, redirect_count_d;

  always_comb begin
    redirect_count_d = redirect_count_q;
    if (reset) begin
      redirect_count_d = '0;
    end else if (redirect && (redirect_count_q != '1)) begin
      redirect_count_d = redirect_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    redirect_count_q <= redirect_count_d;
  end

  assign redirect_count = redirect_count_q;
`endif

endmodule
